pucch_cs_hop_ctrl: RTL and testbench
====================================

PUCCH_CS_HOP_CTRL -- requirements
Module: pucch_cs_hop_ctrl

Interface
REQ-001 Parameter N_SYMB_SLOT, default 14, meaning symbols per slot; legal range 1..14.
REQ-002 Parameter MAX_SLOT, default 159, meaning largest accepted slot number n_slot.
REQ-003 Port clk  in  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1  meaning asynchronous, active-high reset.
REQ-005 Port i_start  in  1  meaning a one-cycle request to compute n_cs for one slot; it is sampled only in IDLE.
REQ-006 Port i_n_id  in  10  meaning the hopping ID n_ID; it is captured on an accepted i_start.
REQ-007 Port i_slot  in  8  meaning the slot number n_slot; it is captured on an accepted i_start.
REQ-008 Port o_gen_load  out  1  meaning the load strobe to the Gold-sequence generator.
REQ-009 Port o_gen_en  out  1  meaning the generator enable; each high cycle advances the generator by 8 bits.
REQ-010 Port o_gen_init  out  31  meaning the generator initial value c_init.
REQ-011 Port i_gen_seq  in  8  meaning generator output byte k; bit m carries c(8k+m).
REQ-012 Port i_gen_valid  in  1  meaning i_gen_seq is valid; the generator asserts it exactly one cycle after each o_gen_en cycle.
REQ-013 Port o_ncs  out  8  meaning n_cs(n_slot, l) = sum over m of c(8*N_SYMB_SLOT*n_slot + 8l + m)*2^m.
REQ-014 Port o_sym_idx  out  4  meaning the symbol index l that belongs to o_ncs.
REQ-015 Port o_ncs_valid  out  1  meaning o_ncs and o_sym_idx are valid this cycle.
REQ-016 Port o_busy  out  1  meaning the FSM is not in IDLE.
REQ-017 Port o_done  out  1  meaning a one-cycle pulse in the cycle after the last symbol has been output.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, RUN and FLUSH.
REQ-019 In IDLE, i_start=1 SHALL capture i_n_id and i_slot, and the next state SHALL be LOAD; i_start SHALL be ignored in every other state.
REQ-020 An i_slot value greater than MAX_SLOT SHALL be clamped to MAX_SLOT at capture.
REQ-021 In LOAD, o_gen_load=1, o_gen_en=0 and o_gen_init={21'b0, n_id} for exactly one cycle, then the FSM SHALL go to RUN.
REQ-022 In RUN, o_gen_en=1 every cycle for exactly T = N_SYMB_SLOT*(n_slot+1) cycles (12-bit issue counter), then the FSM SHALL go to FLUSH.
REQ-023 A 12-bit return counter k SHALL increment on every i_gen_valid while busy and SHALL start at 0 after LOAD.
REQ-024 While k < N_SYMB_SLOT*n_slot, returned bytes are skip bytes and SHALL be discarded with o_ncs_valid=0.
REQ-025 When k >= N_SYMB_SLOT*n_slot, the block SHALL register o_ncs=i_gen_seq, o_sym_idx=k-N_SYMB_SLOT*n_slot and o_ncs_valid=1, giving 1-cycle latency from i_gen_valid.
REQ-026 FSM transition: FLUSH -> IDLE when the last byte (k=T-1) returns, with o_done=1 in the cycle o_ncs_valid for l=N_SYMB_SLOT-1 is seen plus one.
REQ-027 Corner case n_slot=0: RUN SHALL last N_SYMB_SLOT cycles with no skip bytes.
REQ-028 An i_gen_valid outside the busy period SHALL be ignored.
REQ-029 o_ncs_valid SHALL be asserted exactly N_SYMB_SLOT times per request, with l strictly increasing from 0.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, all counters=0 and all outputs=0, including o_gen_init, o_ncs and o_sym_idx, even in the middle of a request.
REQ-031 The first i_start after rst is released SHALL be processed normally.

Configuration
REQ-032 Macro PUCCH_CS_HOP_ABORT_EN defined: the block SHALL have an extra input i_abort (1 bit); i_abort=1 in any busy state SHALL return the FSM to IDLE in the next cycle, with o_gen_en=0, o_ncs_valid=0 from the next cycle on, no o_done, and all remaining returned bytes ignored.
REQ-033 Macro not defined: the i_abort port SHALL be absent, and a request SHALL end only by completion or rst.

Verification
REQ-034 Generator model: byte k = k[7:0]; i_start with n_id=0x3FF, slot=0 -> o_gen_init=0x3FF for one cycle, o_ncs=0..13 with l=0..13, o_done once.
REQ-035 Same model, slot=2 -> 28 skip bytes, o_ncs=28..41, l=0..13, o_busy high for 1+42 cycles plus flush.
REQ-036 slot=200 -> clamped to 159, o_ncs = (2226+l) mod 256 = 178..191.
REQ-037 i_start pulsed during RUN -> ignored; exactly 14 outputs, then a new i_start after o_done is accepted.
REQ-038 rst asserted at output l=5 -> all outputs 0 at once, IDLE, no o_done; the next request completes correctly.
REQ-039 With PUCCH_CS_HOP_ABORT_EN, i_abort at l=3 of slot 1 -> o_ncs_valid stays low after l=3, no o_done, o_busy=0 the next cycle.

Source files
------------

// File: rtl/pucch_cs_hop_ctrl_if.sv
// rtl/pucch_cs_hop_ctrl_if.sv - request, Gold-generator and n_cs result signals of pucch_cs_hop_ctrl
interface pucch_cs_hop_ctrl_if;
  logic        i_start;
  logic [9:0]  i_n_id;
  logic [7:0]  i_slot;
  logic        o_gen_load;
  logic        o_gen_en;
  logic [30:0] o_gen_init;
  logic [7:0]  i_gen_seq;
  logic        i_gen_valid;
  logic [7:0]  o_ncs;
  logic [3:0]  o_sym_idx;
  logic        o_ncs_valid;
  logic        o_busy;
  logic        o_done;

  modport master (
    input  i_start, i_n_id, i_slot, i_gen_seq, i_gen_valid,
    output o_gen_load, o_gen_en, o_gen_init, o_ncs, o_sym_idx, o_ncs_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_n_id, i_slot, i_gen_seq, i_gen_valid,
    input  o_gen_load, o_gen_en, o_gen_init, o_ncs, o_sym_idx, o_ncs_valid, o_busy, o_done
  );
endinterface

// File: rtl/pucch_cs_hop_ctrl.sv
// rtl/pucch_cs_hop_ctrl.sv - PUCCH cyclic-shift hopping n_cs controller; PUCCH_CS_HOP_ABORT_EN adds i_abort
module pucch_cs_hop_ctrl #(
  parameter int N_SYMB_SLOT = 14,
  parameter int MAX_SLOT    = 159
) (
  input  logic clk,
  input  logic rst,
`ifdef PUCCH_CS_HOP_ABORT_EN
  input  logic i_abort,
`endif
  pucch_cs_hop_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  localparam logic [11:0] NS       = 12'(N_SYMB_SLOT);
  localparam logic [7:0]  MAX_S    = 8'(MAX_SLOT);
  localparam logic [3:0]  LAST_SYM = 4'(N_SYMB_SLOT - 1);

  state_t      state_q, state_d;
  logic [9:0]  n_id_q;
  logic [7:0]  slot_q;
  logic [11:0] issue_q;
  logic [11:0] k_q;
  logic [3:0]  sym_q;
  logic [11:0] skip;
  logic [11:0] total;
  logic        abort;
  logic        ret_ok;
  logic        last_ret;

`ifdef PUCCH_CS_HOP_ABORT_EN
  assign abort = i_abort && (state_q != IDLE);
`else
  assign abort = 1'b0;
`endif

  // Bytes before the requested slot are pulled through the generator and dropped.
  assign skip     = NS * {4'd0, slot_q};
  assign total    = skip + NS;
  assign ret_ok   = bus.i_gen_valid && ((state_q == RUN) || (state_q == FLUSH));
  assign last_ret = ret_ok && (k_q == total - 12'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (issue_q == total - 12'd1) state_d = FLUSH;
      FLUSH:   if (last_ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  assign bus.o_gen_load = (state_q == LOAD);
  assign bus.o_gen_en   = (state_q == RUN);
  assign bus.o_gen_init = (state_q == LOAD) ? {21'd0, n_id_q} : 31'd0;
  assign bus.o_busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_id_q          <= '0;
      slot_q          <= '0;
      issue_q         <= '0;
      k_q             <= '0;
      sym_q           <= '0;
      bus.o_ncs       <= '0;
      bus.o_sym_idx   <= '0;
      bus.o_ncs_valid <= 1'b0;
      bus.o_done      <= 1'b0;
    end else begin
      bus.o_ncs_valid <= 1'b0;
      bus.o_done      <= bus.o_ncs_valid && (bus.o_sym_idx == LAST_SYM);
      case (state_q)
        IDLE: if (bus.i_start) begin
          n_id_q <= bus.i_n_id;
          slot_q <= (bus.i_slot > MAX_S) ? MAX_S : bus.i_slot;
        end
        LOAD: begin
          issue_q <= '0;
          k_q     <= '0;
          sym_q   <= '0;
        end
        RUN:     issue_q <= issue_q + 12'd1;
        default: ;
      endcase
      if (ret_ok && !abort) begin
        k_q <= k_q + 12'd1;
        if (k_q >= skip) begin
          bus.o_ncs       <= bus.i_gen_seq;
          bus.o_sym_idx   <= sym_q;
          bus.o_ncs_valid <= 1'b1;
          sym_q           <= sym_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pucch_cs_hop_ctrl.sv
// tb/tb_pucch_cs_hop_ctrl.sv - self-checking bench for pucch_cs_hop_ctrl with a counting byte generator
module tb_pucch_cs_hop_ctrl;
  localparam int N = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef PUCCH_CS_HOP_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  pucch_cs_hop_ctrl_if bus ();

  pucch_cs_hop_ctrl #(.N_SYMB_SLOT(N), .MAX_SLOT(159)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PUCCH_CS_HOP_ABORT_EN
    .i_abort(abort),
`endif
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_l[$];
  int exp_v[$];
  int exp_init = 0;
  int n_load, n_en, n_busy, n_out, n_done, first_ncs, last_ncs;
  bit done_due = 1'b0;
  int gk = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Generator: byte k carries the value k[7:0], one cycle after each enable.
  always @(posedge clk) begin
    if (rst) begin
      bus.i_gen_valid <= 1'b0;
      bus.i_gen_seq   <= 8'd0;
    end else begin
      bus.i_gen_valid <= 1'b0;
      if (bus.o_gen_load) gk <= 0;
      else if (bus.o_gen_en) begin
        bus.i_gen_valid <= 1'b1;
        bus.i_gen_seq   <= 8'(gk);
        gk <= gk + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) done_due = 1'b0;
    else begin
      if (bus.o_busy) n_busy++;
      if (bus.o_gen_en) n_en++;
      if (bus.o_gen_load) begin
        n_load++;
        chk("gen_init", int'(bus.o_gen_init), exp_init);
        chk("gen_en_in_load", int'(bus.o_gen_en), 0);
      end
      chk("done", int'(bus.o_done), done_due ? 1 : 0);
      if (bus.o_done) n_done++;
      done_due = 1'b0;
      if (bus.o_ncs_valid) begin
        if (exp_l.size() == 0) chk("ncs_unexpected", 1, 0);
        else begin
          int l, v;
          l = exp_l.pop_front();
          v = exp_v.pop_front();
          chk("sym_idx", int'(bus.o_sym_idx), l);
          chk("ncs", int'(bus.o_ncs), v);
          if (n_out == 0) first_ncs = int'(bus.o_ncs);
          last_ncs = int'(bus.o_ncs);
          n_out++;
          done_due = (l == N - 1);
        end
      end
    end
  end

  task automatic start_req(input int nid, input int slot);
    int sc;
    sc = (slot > 159) ? 159 : slot;
    exp_init = nid;
    n_load = 0; n_en = 0; n_busy = 0; n_out = 0; n_done = 0;
    first_ncs = -1; last_ncs = -1;
    exp_l.delete(); exp_v.delete();
    for (int l = 0; l < N; l++) begin
      exp_l.push_back(l);
      exp_v.push_back((N * sc + l) % 256);
    end
    @(posedge clk); #1;
    bus.i_n_id  = 10'(nid);
    bus.i_slot  = 8'(slot);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int t, input int glitch);
    for (int c = 0; c < t + 40 && n_done == 0; c++) begin
      @(posedge clk); #1;
      bus.i_start = (c == glitch);
      if (c == glitch) begin
        bus.i_slot = 8'd7;
        bus.i_n_id = 10'h2AA;
      end
    end
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_req(input int slot, input int first, input int last);
    int t;
    t = N * (((slot > 159) ? 159 : slot) + 1);
    chk("outputs", n_out, N);
    chk("done_count", n_done, 1);
    chk("load_count", n_load, 1);
    chk("en_count", n_en, t);
    chk("busy_cycles", n_busy, t + 2);
    chk("first_ncs", first_ncs, first);
    chk("last_ncs", last_ncs, last);
    chk("model_left", exp_l.size(), 0);
  endtask

  task automatic run_req(input int nid, input int slot, input int glitch, input int first, input int last);
    start_req(nid, slot);
    wait_done(N * (((slot > 159) ? 159 : slot) + 1), glitch);
    check_req(slot, first, last);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ncs"}, int'(bus.o_ncs), 0);
    chk({tag, "_sym_idx"}, int'(bus.o_sym_idx), 0);
    chk({tag, "_ncs_valid"}, int'(bus.o_ncs_valid), 0);
    chk({tag, "_busy"}, int'(bus.o_busy), 0);
    chk({tag, "_done"}, int'(bus.o_done), 0);
    chk({tag, "_gen_en"}, int'(bus.o_gen_en), 0);
    chk({tag, "_gen_load"}, int'(bus.o_gen_load), 0);
    chk({tag, "_gen_init"}, int'(bus.o_gen_init), 0);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_n_id  = 10'd0;
    bus.i_slot  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    run_req(10'h3FF, 0, -1, 0, 13);
    run_req(10'h155, 2, -1, 28, 41);
    run_req(0, 200, -1, 178, 191);
    run_req(10'h011, 18, -1, 252, 9);
    run_req(10'h0A5, 1, 5, 14, 27);
    run_req(10'h05A, 3, -1, 42, 55);

    // Reset while l=5 is on the output.
    start_req(5, 4);
    for (int c = 0; c < 200 && n_out < 6; c++) begin
      @(negedge clk); #1;
    end
    chk("rst_reached_l5", n_out, 6);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    exp_l.delete(); exp_v.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_done", n_done, 0);
    chk("rst_outputs", n_out, 6);
    run_req(10'h123, 0, -1, 0, 13);

`ifdef PUCCH_CS_HOP_ABORT_EN
    start_req(9, 1);
    for (int c = 0; c < 200 && n_out < 4; c++) begin
      @(negedge clk); #1;
    end
    chk("abort_reached_l3", n_out, 4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_l.delete(); exp_v.delete();
    chk("abort_busy", int'(bus.o_busy), 0);
    chk("abort_ncs_valid", int'(bus.o_ncs_valid), 0);
    chk("abort_gen_en", int'(bus.o_gen_en), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", n_done, 0);
    chk("abort_outputs", n_out, 4);
    run_req(10'h001, 1, -1, 14, 27);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
